// File: rtl/feeder_systolic_if.sv
// Bundle of control, write, read and result signals between a host and feeder_systolic.
// The host drives the master side; the feeder implements the slave side.
interface feeder_systolic_if #(
  parameter int unsigned M          = 4,
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 32
);
  localparam int unsigned ColW = (N > 1) ? $clog2(N) : 1;

  logic                      start;
  logic                      valid_write;
  logic [M*DATA_WIDTH-1:0]   data_in;
  logic [1:0]                stride;
  logic [ADDR_WIDTH-1:0]     chans_per_mem;
  logic [ADDR_WIDTH-1:0]     in_cols;
  logic [ADDR_WIDTH-1:0]     k_dimension;
  logic [ADDR_WIDTH-1:0]     o_dimension;
  logic                      w_wr;
  logic [ColW-1:0]           w_col;
  logic [M*DATA_WIDTH-1:0]   w_data;
  logic                      ram_full;
  logic [1:0]                state;
  logic [M*DATA_WIDTH-1:0]   data_out;
  logic                      act_valid;
  logic                      last_out;
  logic [63:0]               read_counter;
  logic [N*ACC_WIDTH-1:0]    psum;
  logic                      valid_out;

  modport master (
    output start, valid_write, data_in, stride, chans_per_mem, in_cols, k_dimension,
           o_dimension, w_wr, w_col, w_data,
    input  ram_full, state, data_out, act_valid, last_out, read_counter, psum, valid_out
  );

  modport slave (
    input  start, valid_write, data_in, stride, chans_per_mem, in_cols, k_dimension,
           o_dimension, w_wr, w_col, w_data,
    output ram_full, state, data_out, act_valid, last_out, read_counter, psum, valid_out
  );
endinterface

// File: rtl/feeder_systolic.sv
// Activation RAM plus convolution-order read sequencer feeding a weight-stationary
// MxN systolic mesh with input skew and output de-skew.
module feeder_systolic #(
  parameter int unsigned M          = 4,
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ACC_WIDTH  = 32
) (
  input logic              clk,
  input logic              rst,
  feeder_systolic_if.slave bus
);
  localparam int unsigned ColW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned AW      = ACC_WIDTH;
  localparam int unsigned Lat     = M + N;
  localparam int unsigned WStages = M + N - 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [M*DW-1:0]       word_t;
  localparam addr_t AOne = addr_t'(1);

  logic [1:0]  state_q, state_d;
  addr_t       total_q, total_d, wr_ptr_q, wr_ptr_d;
  addr_t       oy_q, oy_d, ox_q, ox_d, ky_q, ky_d, kx_q, kx_d, c_q, c_d;
  logic        ram_full_q, ram_full_d;
  logic [63:0] rd_cnt_q, rd_cnt_d;
  addr_t       s_eff, rd_addr, kmax, omax, cmax;
  logic        wr_en, rd_en, rd_last;
  word_t       mem [DEPTH];
  word_t       dout_q;
  logic        act_valid_q, last_q;

  always_comb begin
    s_eff   = {{(ADDR_WIDTH-2){1'b0}}, (bus.stride == 2'd0) ? 2'd1 : bus.stride};
    rd_addr = ((oy_q * s_eff + ky_q) * bus.in_cols + ox_q * s_eff + kx_q) * bus.chans_per_mem
              + c_q;
    kmax    = bus.k_dimension - AOne;
    omax    = bus.o_dimension - AOne;
    cmax    = bus.chans_per_mem - AOne;
    wr_en   = (state_q == StWrite) && bus.valid_write && !ram_full_q;
    rd_en   = (state_q == StRead);
    rd_last = (c_q == cmax) && (kx_q == kmax) && (ky_q == kmax) && (ox_q == omax) &&
              (oy_q == omax);

    state_d    = state_q;
    total_d    = total_q;
    wr_ptr_d   = wr_ptr_q;
    ram_full_d = ram_full_q;
    rd_cnt_d   = rd_cnt_q;
    oy_d = oy_q; ox_d = ox_q; ky_d = ky_q; kx_d = kx_q; c_d = c_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StWrite;
          total_d  = bus.in_cols * bus.in_cols * bus.chans_per_mem;
          wr_ptr_d = '0;
        end
      end
      StWrite: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + AOne;
          if (wr_ptr_d == total_q) begin
            ram_full_d = 1'b1;
            state_d    = StRead;
          end
        end
      end
      StRead: begin
        rd_cnt_d = rd_cnt_q + 64'd1;
        // Odometer: c innermost, then kx, ky, ox, oy.
        if (c_q != cmax) c_d = c_q + AOne;
        else begin
          c_d = '0;
          if (kx_q != kmax) kx_d = kx_q + AOne;
          else begin
            kx_d = '0;
            if (ky_q != kmax) ky_d = ky_q + AOne;
            else begin
              ky_d = '0;
              if (ox_q != omax) ox_d = ox_q + AOne;
              else begin
                ox_d = '0;
                oy_d = oy_q + AOne;
              end
            end
          end
        end
        if (rd_last) state_d = StDone;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle; total_q <= '0; wr_ptr_q <= '0; ram_full_q <= 1'b0; rd_cnt_q <= '0;
      oy_q <= '0; ox_q <= '0; ky_q <= '0; kx_q <= '0; c_q <= '0;
      dout_q <= '0; act_valid_q <= 1'b0; last_q <= 1'b0;
    end else begin
      state_q <= state_d; total_q <= total_d; wr_ptr_q <= wr_ptr_d;
      ram_full_q <= ram_full_d; rd_cnt_q <= rd_cnt_d;
      oy_q <= oy_d; ox_q <= ox_d; ky_q <= ky_d; kx_q <= kx_d; c_q <= c_d;
      if (rd_en) dout_q <= mem[rd_addr];
      act_valid_q <= rd_en;
      last_q      <= rd_en && rd_last;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= bus.data_in;
  end

  // Systolic mesh
  logic [DW-1:0]   row_in [M];
  logic [DW-1:0]   skew_q [M][M];
  logic [DW-1:0]   a_d [M][N];
  logic [DW-1:0]   a_q [M][N];
  logic [DW-1:0]   w_q [M][N];
  logic [AW-1:0]   p_d [M][N];
  logic [AW-1:0]   p_q [M][N];
  logic [AW-1:0]   dsk_q [N][N];
  logic [AW-1:0]   col_out [N];
  logic            ws_wr [WStages];
  logic [ColW-1:0] ws_col [WStages];
  word_t           ws_data [WStages];
  logic            wp_wr_q [WStages-1];
  logic [ColW-1:0] wp_col_q [WStages-1];
  word_t           wp_data_q [WStages-1];
  logic [Lat-1:0]  vld_q;
  logic [N*AW-1:0] psum_q;

  // Weight writes travel with the skew so PE(m,n) updates exactly after the beat
  // presented in the write cycle has passed it.
  for (genvar k = 0; k < WStages; k++) begin : g_wstage
    if (k == 0) begin : g_in
      assign ws_wr[k]   = bus.w_wr;
      assign ws_col[k]  = bus.w_col;
      assign ws_data[k] = bus.w_data;
    end else begin : g_pipe
      assign ws_wr[k]   = wp_wr_q[k-1];
      assign ws_col[k]  = wp_col_q[k-1];
      assign ws_data[k] = wp_data_q[k-1];
    end
  end

  for (genvar m = 0; m < M; m++) begin : g_row
    if (m == 0) begin : g_direct
      assign row_in[m] = dout_q[m*DW +: DW];
    end else begin : g_skew
      assign row_in[m] = skew_q[m][m-1];
    end
    for (genvar n = 0; n < N; n++) begin : g_pe
      if (n == 0) begin : g_a0
        assign a_d[m][n] = row_in[m];
      end else begin : g_an
        assign a_d[m][n] = a_q[m][n-1];
      end
      if (m == 0) begin : g_p0
        assign p_d[m][n] = AW'(a_d[m][n]) * AW'(w_q[m][n]);
      end else begin : g_pm
        assign p_d[m][n] = p_q[m-1][n] + AW'(a_d[m][n]) * AW'(w_q[m][n]);
      end
    end
  end

  for (genvar n = 0; n < N; n++) begin : g_out
    if (n == N - 1) begin : g_last
      assign col_out[n] = p_q[M-1][n];
    end else begin : g_dsk
      assign col_out[n] = dsk_q[n][N-2-n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < M; m++) begin
        for (int j = 0; j < M; j++) skew_q[m][j] <= '0;
        for (int n = 0; n < N; n++) begin
          a_q[m][n] <= '0; p_q[m][n] <= '0; w_q[m][n] <= '0;
        end
      end
      for (int n = 0; n < N; n++) begin
        for (int j = 0; j < N; j++) dsk_q[n][j] <= '0;
      end
      for (int k = 0; k < WStages - 1; k++) begin
        wp_wr_q[k] <= 1'b0; wp_col_q[k] <= '0; wp_data_q[k] <= '0;
      end
      vld_q  <= '0;
      psum_q <= '0;
    end else begin
      for (int m = 0; m < M; m++) begin
        skew_q[m][0] <= dout_q[m*DW +: DW];
        for (int j = 1; j < M; j++) skew_q[m][j] <= skew_q[m][j-1];
        for (int n = 0; n < N; n++) begin
          a_q[m][n] <= a_d[m][n];
          p_q[m][n] <= p_d[m][n];
          if (ws_wr[m+n] && ws_col[m+n] == ColW'(n)) w_q[m][n] <= ws_data[m+n][m*DW +: DW];
        end
      end
      for (int n = 0; n < N; n++) begin
        dsk_q[n][0] <= p_q[M-1][n];
        for (int j = 1; j < N; j++) dsk_q[n][j] <= dsk_q[n][j-1];
        psum_q[n*AW +: AW] <= col_out[n];
      end
      wp_wr_q[0] <= ws_wr[0]; wp_col_q[0] <= ws_col[0]; wp_data_q[0] <= ws_data[0];
      for (int k = 1; k < WStages - 1; k++) begin
        wp_wr_q[k] <= wp_wr_q[k-1]; wp_col_q[k] <= wp_col_q[k-1];
        wp_data_q[k] <= wp_data_q[k-1];
      end
      vld_q <= {vld_q[Lat-2:0], act_valid_q};
    end
  end

  assign bus.ram_full     = ram_full_q;
  assign bus.state        = state_q;
  assign bus.data_out     = dout_q;
  assign bus.act_valid    = act_valid_q;
  assign bus.last_out     = last_q;
  assign bus.read_counter = rd_cnt_q;
  assign bus.psum         = psum_q;
  assign bus.valid_out    = vld_q[Lat-1];
endmodule

// File: tb/tb_feeder_systolic.sv
// Scoreboard bench for feeder_systolic: expected beats and psums are queued as each
// run is loaded and retired as the DUT presents them.
module tb_feeder_systolic;
  localparam int unsigned M = 4, N = 4, DW = 8, AWD = 16, DEPTH = 1024, ACC = 32;
  localparam int unsigned Lat = M + N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  feeder_systolic_if #(.M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .ACC_WIDTH(ACC)) bus();

  feeder_systolic #(
    .M(M), .N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .DEPTH(DEPTH), .ACC_WIDTH(ACC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [M*DW-1:0] data;
    logic            last;
  } act_exp_t;

  int n_checks = 0, n_errors = 0;
  act_exp_t        exp_act_q[$];
  logic [N*ACC-1:0] exp_ps_q[$];
  int              act_t_q[$];
  logic [DW-1:0]   obs_q[$];
  int              cyc = 0, act_cnt = 0, vo_cnt = 0;
  act_exp_t        mon_e;
  int              mon_t;
  logic [N*ACC-1:0] last_psum;
  logic [M*DW-1:0] mdl_mem [256];
  logic [DW-1:0]   w_mdl [M][N];
  int exp_s1[8] = '{0, 1, 4, 5, 1, 2, 5, 6};
  int exp_s2[9] = '{0, 2, 4, 10, 12, 14, 20, 22, 24};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.act_valid === 1'b1) begin
      act_cnt++;
      act_t_q.push_back(cyc);
      obs_q.push_back(bus.data_out[DW-1:0]);
      check_eq("act_pending", 128'(exp_act_q.size() > 0), 128'd1);
      if (exp_act_q.size() > 0) begin
        mon_e = exp_act_q.pop_front();
        check_eq("data_out", 128'(bus.data_out), 128'(mon_e.data));
        check_eq("last_out", 128'(bus.last_out), 128'(mon_e.last));
      end
    end
    if (bus.valid_out === 1'b1) begin
      vo_cnt++;
      last_psum = bus.psum;
      check_eq("psum_pending", 128'(exp_ps_q.size() > 0 && act_t_q.size() > 0), 128'd1);
      if (exp_ps_q.size() > 0 && act_t_q.size() > 0) begin
        check_eq("psum", 128'(bus.psum), 128'(exp_ps_q.pop_front()));
        mon_t = act_t_q.pop_front();
        check_eq("vo_latency", 128'(cyc - mon_t), 128'(Lat));
      end
    end
  end

  function automatic logic [M*DW-1:0] word_of(input int i, input int pat);
    logic [M*DW-1:0] w;
    for (int u = 0; u < M; u++) begin
      case (pat)
        0:       w[u*DW +: DW] = DW'(i);
        1:       w[u*DW +: DW] = DW'(u + 1);
        2:       w[u*DW +: DW] = 8'hFF;
        default: w[u*DW +: DW] = DW'(i * 7 + u * 3 + 1);
      endcase
    end
    return w;
  endfunction

  function automatic logic [N*ACC-1:0] psum_of(input logic [M*DW-1:0] a);
    logic [N*ACC-1:0] r;
    logic [ACC-1:0]   acc;
    for (int n = 0; n < N; n++) begin
      acc = '0;
      for (int m = 0; m < M; m++) acc += ACC'(a[m*DW +: DW]) * ACC'(w_mdl[m][n]);
      r[n*ACC +: ACC] = acc;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    exp_act_q.delete(); exp_ps_q.delete(); act_t_q.delete(); obs_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush();
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) w_mdl[m][n] = '0;
  endtask

  task automatic load_weights(input int pat);
    for (int col = 0; col < N; col++) begin
      bus.w_wr  = 1'b1;
      bus.w_col = col[$clog2(N)-1:0];
      for (int m = 0; m < M; m++) begin
        case (pat)
          0:       w_mdl[m][col] = (m == col) ? 8'd1 : 8'd0;
          1:       w_mdl[m][col] = 8'hFF;
          default: w_mdl[m][col] = DW'(m * N + col + 1);
        endcase
        bus.w_data[m*DW +: DW] = w_mdl[m][col];
      end
      tick();
    end
    bus.w_wr = 1'b0;
    repeat (Lat) tick();
  endtask

  task automatic run_conv(input int ic, input int cpm, input int kd, input int od,
                          input logic [1:0] st, input int pat, input bit wait_done);
    int t, s, nrd, idx, guard, addr;
    logic [M*DW-1:0] w;
    t   = ic * ic * cpm;
    s   = (st == 2'd0) ? 1 : int'(st);
    nrd = od * od * kd * kd * cpm;
    bus.in_cols = AWD'(ic); bus.chans_per_mem = AWD'(cpm);
    bus.k_dimension = AWD'(kd); bus.o_dimension = AWD'(od); bus.stride = st;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("state_write", 128'(bus.state), 128'd1);
    for (int i = 0; i < t; i++) begin
      w = word_of(i, pat);
      mdl_mem[i] = w;
      bus.valid_write = 1'b1;
      bus.data_in = w;
      if (i == t - 1) check_eq("not_full_early", 128'(bus.ram_full), 128'd0);
      tick();
    end
    check_eq("ram_full", 128'(bus.ram_full), 128'd1);
    check_eq("state_read", 128'(bus.state), 128'd2);
    bus.data_in = {M{8'hA5}};
    idx = 0;
    for (int oy = 0; oy < od; oy++)
      for (int ox = 0; ox < od; ox++)
        for (int ky = 0; ky < kd; ky++)
          for (int kx = 0; kx < kd; kx++)
            for (int c = 0; c < cpm; c++) begin
              addr = ((oy * s + ky) * ic + ox * s + kx) * cpm + c;
              exp_act_q.push_back('{data: mdl_mem[addr], last: (idx == nrd - 1)});
              exp_ps_q.push_back(psum_of(mdl_mem[addr]));
              idx++;
            end
    tick();
    bus.valid_write = 1'b0;
    if (wait_done) begin
      guard = 0;
      while ((bus.state != 2'd3 || exp_act_q.size() != 0 || exp_ps_q.size() != 0) &&
             guard < 4000) begin
        tick();
        guard++;
      end
      check_eq("run_complete", 128'(guard < 4000), 128'd1);
      check_eq("read_counter", 128'(bus.read_counter), 128'(nrd));
      check_eq("full_in_done", 128'(bus.ram_full), 128'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0, v0;
    bus.start = 1'b0; bus.valid_write = 1'b0; bus.data_in = '0; bus.stride = 2'd1;
    bus.chans_per_mem = '0; bus.in_cols = '0; bus.k_dimension = '0; bus.o_dimension = '0;
    bus.w_wr = 1'b0; bus.w_col = '0; bus.w_data = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    flush();
    check_eq("rst_state", 128'(bus.state), 128'd0);
    check_eq("rst_ram_full", 128'(bus.ram_full), 128'd0);
    check_eq("rst_act_valid", 128'(bus.act_valid), 128'd0);
    check_eq("rst_valid_out", 128'(bus.valid_out), 128'd0);
    check_eq("rst_read_counter", 128'(bus.read_counter), 128'd0);
    check_eq("rst_psum", 128'(bus.psum), 128'd0);
    check_eq("rst_data_out", 128'(bus.data_out), 128'd0);

    // Fill to full with stride 0 (treated as 1); reads every word once in order
    load_weights(0);
    run_conv(4, 1, 1, 4, 2'd0, 0, 1'b1);

    // Stride 1, 2x2 kernel, 3x3 output
    do_reset(); load_weights(0);
    a0 = act_cnt;
    run_conv(4, 1, 2, 3, 2'd1, 0, 1'b1);
    check_eq("s1_beats", 128'(act_cnt - a0), 128'd36);
    for (int i = 0; i < 8; i++)
      if (i < obs_q.size()) check_eq("s1_order", 128'(obs_q[i]), 128'(exp_s1[i]));

    // Stride 2, 1x1 kernel
    do_reset(); load_weights(2);
    run_conv(5, 1, 1, 3, 2'd2, 0, 1'b1);
    check_eq("s2_beats", 128'(obs_q.size()), 128'd9);
    for (int i = 0; i < 9; i++)
      if (i < obs_q.size()) check_eq("s2_order", 128'(obs_q[i]), 128'(exp_s2[i]));

    // Multi-channel words with a dense weight matrix
    do_reset(); load_weights(2);
    run_conv(3, 2, 2, 2, 2'd1, 3, 1'b1);

    // Identity weights, single beat 1,2,3,4
    do_reset(); load_weights(0);
    run_conv(1, 1, 1, 1, 2'd1, 1, 1'b1);
    check_eq("identity_psum", 128'(last_psum), {32'd4, 32'd3, 32'd2, 32'd1});

    // Largest operands: no wrap at 32 bits
    do_reset(); load_weights(1);
    run_conv(1, 1, 1, 1, 2'd1, 2, 1'b1);
    check_eq("max_psum", 128'(last_psum), {4{32'd260100}});

    // Reset in the middle of READ aborts everything
    do_reset(); load_weights(0);
    run_conv(4, 1, 2, 3, 2'd1, 0, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush();
    check_eq("abort_state", 128'(bus.state), 128'd0);
    check_eq("abort_valid_out", 128'(bus.valid_out), 128'd0);
    check_eq("abort_read_counter", 128'(bus.read_counter), 128'd0);
    check_eq("abort_act_valid", 128'(bus.act_valid), 128'd0);
    a0 = act_cnt; v0 = vo_cnt;
    repeat (40) tick();
    check_eq("abort_no_act", 128'(act_cnt - a0), 128'd0);
    check_eq("abort_no_vo", 128'(vo_cnt - v0), 128'd0);
    check_eq("abort_idle", 128'(bus.state), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/feeder_systolic.md
FEEDER_SYSTOLIC -- requirements
Module: feeder_systolic

Interface
Parameters:
REQ-001 M, default 4: array rows, activation lanes per beat, channels per stored word.
REQ-002 N, default 4: array columns, output results per beat.
REQ-003 DATA_WIDTH, default 8: activation/weight width.
REQ-004 ADDR_WIDTH, default 16: address and count width.
REQ-005 DEPTH, default 1024: activation RAM words.
REQ-006 ACC_WIDTH, default 32: accumulator and result width.

Ports (name, direction, width, meaning):
REQ-007 clk  in  1  sole clock; all logic on the rising edge.
REQ-008 rst  in  1  reset; synchronous, active-high.
REQ-009 start  in  1  level; enables the write phase.
REQ-010 valid_write  in  1  data_in holds a valid word this cycle.
REQ-011 data_in  in  M*DATA_WIDTH  packed channel word; lane u at bits [(u+1)*DW-1 : u*DW].
REQ-012 stride  in  2  convolution stride; 0 is treated as 1.
REQ-013 chans_per_mem  in  ADDR_WIDTH  channel groups (words) per pixel.
REQ-014 in_cols  in  ADDR_WIDTH  square input dimension.
REQ-015 k_dimension  in  ADDR_WIDTH  square kernel dimension.
REQ-016 o_dimension  in  ADDR_WIDTH  square output dimension.
REQ-017 w_wr, w_col, w_data  in  1 / clog2(N) / M*DATA_WIDTH  weight write; lane m of w_data goes to W[m][w_col].
REQ-018 ram_full  out  1  all activation words have been written.
REQ-019 state  out  2  FSM state: 0=IDLE, 1=WRITE, 2=READ, 3=DONE.
REQ-020 data_out  out  M*DATA_WIDTH  activation beat fed to the array.
REQ-021 act_valid  out  1  data_out is valid.
REQ-022 last_out  out  1  one-cycle pulse with the final act_valid beat.
REQ-023 read_counter  out  64  number of RAM reads issued.
REQ-024 psum  out  N*ACC_WIDTH  results; column n at bits [(n+1)*AW-1 : n*AW].
REQ-025 valid_out  out  1  psum is valid.

Function
REQ-026 Total words: T = in_cols*in_cols*chans_per_mem, latched at the IDLE->WRITE transition.
REQ-027 IDLE->WRITE when start=1.
REQ-028 In WRITE, each cycle with valid_write=1 and ram_full=0:
- data_in is stored at wr_ptr;
- wr_ptr increments.
REQ-029 Writes made in any state other than WRITE, or while ram_full=1, are ignored.
REQ-030 When wr_ptr reaches T, ram_full=1 on the following cycle, and the FSM goes WRITE->READ in that same cycle.
REQ-031 Read order, nested outermost to innermost: oy, ox in [0, o_dimension); ky, kx in [0, k_dimension); c in [0, chans_per_mem).
REQ-032 One read is issued per cycle in READ, at addr = ((oy*s+ky)*in_cols + ox*s+kx)*chans_per_mem + c, where s is the effective stride.
REQ-033 RAM read is registered: data_out and act_valid appear exactly 1 cycle after the read is issued.
REQ-034 data_out lane u equals stored-word lane u.
REQ-035 read_counter increments once per read issued.
REQ-036 After the last read, the FSM goes READ->DONE.
REQ-037 last_out=1 on the cycle the final act_valid beat is presented.
REQ-038 DONE holds until rst; ram_full stays 1 in DONE.
REQ-039 Weight writes (w_wr) are accepted in any state; a write to W[*][col] in the same cycle as an array input takes effect from the next beat.
REQ-040 Array: a weight-stationary MxN systolic mesh with input skew and output de-skew.
REQ-041 For each act_valid beat a, the matching psum[n] = sum over m of a[m]*W[m][n].
REQ-042 Arithmetic: operands are unsigned; the sum wraps modulo 2^ACC_WIDTH.
REQ-043 valid_out asserts exactly M+N cycles after the matching act_valid, one beat per input beat, in order.
REQ-044 The array is fully pipelined; back-to-back input beats give back-to-back outputs.
REQ-045 Total valid_out beats = o_dimension^2 * k_dimension^2 * chans_per_mem.

Reset
REQ-046 With rst=1 at a clock edge, the following clear: FSM to IDLE; wr_ptr, read indices and read_counter to 0; ram_full, act_valid, last_out and valid_out to 0; data_out and psum to 0; all weights to 0; all pipeline valids cleared.
REQ-047 RAM contents need not be cleared by reset.
REQ-048 Reset mid-operation aborts all work in progress.
REQ-049 After reset deasserts, no output beat appears until a new start.

Verification
REQ-050 Fill/full: M=4, in_cols=4, chans_per_mem=1, write 16 words with valid_write=1 -> ram_full=1 after the 16th write; a 17th word is ignored; state reads 1 then 2.
REQ-051 Stride 1: in_cols=4, k_dimension=2, o_dimension=3, word i = i in every lane -> first data_out lanes follow word order 0,1,4,5 then 1,2,5,6; 36 beats; last_out on beat 36; read_counter=36.
REQ-052 Stride 2: in_cols=5, k_dimension=1, o_dimension=3 -> words read in order 0,2,4,10,12,14,20,22,24.
REQ-053 Compute: W = identity, a beat with lanes 1,2,3,4 -> psum columns 1,2,3,4, with valid_out exactly 8 cycles after act_valid.
REQ-054 Overflow: all weights 255, all activations 255 -> each column equals 4*65025 = 260100, no wrap at 32 bits.
REQ-055 Reset mid-READ: rst pulsed -> state=0, valid_out=0, read_counter=0 next cycle; no further output beats.
